// File: rtl/sequential_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// sequential_multiplier_pkg
// Shared constants and types for the registered signed multiplier.
//   WIDTH      : default operand width in bits (product is 2*WIDTH)
//   operand_t  : signed operand type
//   product_t  : signed full-precision product type
//   sign_extend: widens a signed operand to product width
// ---------------------------------------------------------------------------
package sequential_multiplier_pkg;

  localparam int WIDTH = 32;

  typedef logic signed [WIDTH-1:0]   operand_t;
  typedef logic signed [2*WIDTH-1:0] product_t;

  // Replicates the operand sign bit into the upper half so that the
  // shift-and-add core works on true two's-complement values.
  function automatic product_t sign_extend(input operand_t value);
    product_t extended;
    extended = {{WIDTH{value[WIDTH-1]}}, value};
    return extended;
  endfunction

endpackage

// File: rtl/seq_mult_core.sv
// ---------------------------------------------------------------------------
// seq_mult_core
// Purely combinational signed multiplier using an unrolled radix-2
// shift-and-add. There is no clock; the result settles from the operands.
// Ports:
//   multiplicand : input  signed [WIDTH-1:0]
//   multiplier   : input  signed [WIDTH-1:0]
//   product      : output signed [2*WIDTH-1:0], exact two's-complement product
// ---------------------------------------------------------------------------
module seq_mult_core
  import sequential_multiplier_pkg::*;
#(
  parameter int WIDTH = sequential_multiplier_pkg::WIDTH
) (
  input  logic signed [WIDTH-1:0]   multiplicand,
  input  logic signed [WIDTH-1:0]   multiplier,
  output logic signed [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_ext;
  logic [2*WIDTH-1:0] mplier_ext;
  logic [2*WIDTH-1:0] acc;

  // Both operands are sign-extended to the full product width. Summing the
  // shifted multiplicand for every set bit of the extended multiplier and
  // keeping the low 2*WIDTH bits yields the exact signed product, because
  // arithmetic modulo 2^(2*WIDTH) treats the extended values as two's
  // complement without any final correction step.
  always_comb begin
    mcand_ext  = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
    mplier_ext = {{WIDTH{multiplier[WIDTH-1]}}, multiplier};
    acc        = '0;
    for (int i = 0; i < 2*WIDTH; i++) begin
      if (mplier_ext[i]) begin
        acc = acc + (mcand_ext << i);
      end
    end
  end

  assign product = signed'(acc);

endmodule

// File: rtl/sequential_multiplier_withregs.sv
// ---------------------------------------------------------------------------
// sequential_multiplier_withregs
// Registered signed multiplier: operands are captured on the rising clock
// edge and a combinational shift-and-add core produces the full-precision
// product from the registered values (one-edge latency, one pair per cycle).
// Ports:
//   a      : input  signed [WIDTH-1:0], multiplicand
//   b      : input  signed [WIDTH-1:0], multiplier
//   clk    : input, sole clock, rising edge
//   reset  : input, synchronous active-high, clears the operand registers
//   en     : input, capture enable for the operand registers
//   result : output signed [2*WIDTH-1:0], product of the registered operands
// ---------------------------------------------------------------------------
module sequential_multiplier_withregs
  import sequential_multiplier_pkg::*;
#(
  parameter int WIDTH = sequential_multiplier_pkg::WIDTH
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  output logic signed [2*WIDTH-1:0] result
);

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;

  // Operand registers. Reset wins over enable so a reset edge always
  // discards whatever pair is presented; with en low the last pair is held,
  // which keeps the product stable regardless of input activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (en) begin
      a_q <= a;
      b_q <= b;
    end
  end

  seq_mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .multiplicand(a_q),
    .multiplier  (b_q),
    .product     (result)
  );

endmodule

// File: tb/tb_sequential_multiplier_withregs.sv
// ---------------------------------------------------------------------------
// tb_sequential_multiplier_withregs
// Self-checking bench for the registered signed multiplier. A behavioural
// model of the operand registers computes the expected product with the
// built-in signed multiply; expectations are queued at each clock edge and
// popped once the DUT output has settled.
// ---------------------------------------------------------------------------
module tb_sequential_multiplier_withregs;

  localparam int W = 32;

  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic                  clk;
  logic                  reset;
  logic                  en;
  logic signed [2*W-1:0] result;

  logic signed [W-1:0] model_a;
  logic signed [W-1:0] model_b;
  longint              expQueue[$];

  int checkCount = 0;
  int passCount  = 0;

  sequential_multiplier_withregs #(
    .WIDTH(W)
  ) dut (
    .a     (a),
    .b     (b),
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .result(result)
  );

  // 50-unit clock period
  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Watchdog so the run always ends even if the clock stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, push the
  // expected product, then pop and compare once the output has settled
  task automatic applyStimulus(input string tag, input logic signed [W-1:0] aIn,
                               input logic signed [W-1:0] bIn, input logic enIn,
                               input logic resetIn);
    longint pa;
    longint pb;
    longint expected;
    @(negedge clk);
    a     = aIn;
    b     = bIn;
    en    = enIn;
    reset = resetIn;
    @(posedge clk);
    if (resetIn) begin
      model_a = '0;
      model_b = '0;
    end else if (enIn) begin
      model_a = aIn;
      model_b = bIn;
    end
    pa = longint'(model_a);
    pb = longint'(model_b);
    expQueue.push_back(pa * pb);
    #1;
    if (expQueue.size() == 0) begin
      checkOutput({tag, "_queue"}, 0, 1);
    end else begin
      expected = expQueue.pop_front();
      checkOutput(tag, longint'(result), expected);
    end
  endtask

  initial begin
    a       = '0;
    b       = '0;
    en      = 1'b1;
    reset   = 1'b1;
    model_a = '0;
    model_b = '0;

    // Reset held for two edges with en high
    applyStimulus("reset0", 5, -7, 1'b1, 1'b1);
    applyStimulus("reset1", 5, -7, 1'b1, 1'b1);
    checkOutput("reset_zero", longint'(result), 0);

    // Directed products
    applyStimulus("5x-7",   5,   -7, 1'b1, 1'b0);
    checkOutput("5x-7_lit", longint'(result), -35);
    applyStimulus("2x3",    2,    3, 1'b1, 1'b0);
    applyStimulus("-12x-4", -12, -4, 1'b1, 1'b0);
    checkOutput("-12x-4_lit", longint'(result), 48);
    applyStimulus("-9x5",   -9,   5, 1'b1, 1'b0);
    applyStimulus("11x0",   11,   0, 1'b1, 1'b0);
    checkOutput("11x0_lit", longint'(result), 0);
    applyStimulus("10x1",   10,   1, 1'b1, 1'b0);
    applyStimulus("-1x-7",  -1,  -7, 1'b1, 1'b0);

    // Extremes
    applyStimulus("min_x_min", 32'sh80000000, 32'sh80000000, 1'b1, 1'b0);
    checkOutput("min_x_min_lit", longint'(result), 64'sd4611686018427387904);
    applyStimulus("max_x_min", 32'sh7fffffff, 32'sh80000000, 1'b1, 1'b0);
    checkOutput("max_x_min_lit", longint'(result), -64'sd4611686016279904256);
    applyStimulus("-1x-1", -1, -1, 1'b1, 1'b0);
    checkOutput("-1x-1_lit", longint'(result), 1);

    // Hold behaviour: capture 4x6, then disable and change the inputs
    applyStimulus("4x6", 4, 6, 1'b1, 1'b0);
    applyStimulus("hold0", 3, 3, 1'b0, 1'b0);
    applyStimulus("hold1", 3, 3, 1'b0, 1'b0);
    #10;
    a = 100;
    b = -100;
    #5;
    checkOutput("hold_midcycle", longint'(result), 24);
    applyStimulus("resume", 3, 3, 1'b1, 1'b0);
    checkOutput("resume_lit", longint'(result), 9);

    // Inputs changing between enabled edges must not disturb the output
    #10;
    a = -55;
    b = 77;
    #5;
    checkOutput("between_edges", longint'(result), 9);

    // Mid-stream reset has priority over en, then release
    applyStimulus("midreset", 7, 7, 1'b1, 1'b1);
    checkOutput("midreset_lit", longint'(result), 0);
    applyStimulus("release", 7, 7, 1'b1, 1'b0);
    checkOutput("release_lit", longint'(result), 49);

    // Random back-to-back pairs, with occasional enable drops
    for (int i = 0; i < 40; i++) begin
      applyStimulus($sformatf("rand%0d", i), signed'($urandom), signed'($urandom),
                    ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
